// File: rtl/test_stream_pkg.sv
// Shared definitions for the multi-lane test-stream generator: FSM encoding,
// pattern mode codes, header marker and CRC-8 polynomial.
package test_stream_pkg;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        HEAD = 5'b00010,
        SHFT = 5'b00100,
        TRLR = 5'b01000,
        FIN  = 5'b10000
    } state_t;

    localparam logic [1:0] MODE_DEC  = 2'd0;
    localparam logic [1:0] MODE_PRBS = 2'd1;
    localparam logic [1:0] MODE_FIX  = 2'd2;
    localparam logic [1:0] MODE_ALT  = 2'd3;

    localparam logic [3:0] HDR_MARK  = 4'b1011;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Bit counter width: covers both the 8-bit header/trailer and words up to 32 bits.
    localparam int BIT_W = 6;

endpackage

// File: rtl/test_stream_crc8.sv
// Serial CRC-8 (x^8+x^2+x+1), MSB first, non-reflected, with clear and enable.
module test_stream_crc8
    import test_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic       feedback;
    logic [7:0] crc_next;

    always_comb begin
        feedback = crc[7] ^ bit_in;
        crc_next = {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/test_stream_gen_mc.sv
// Multi-lane serial test-stream generator: header, pattern words, optional CRC trailer.
// Define TEST_STREAM_CRC_EN to add a per-lane CRC-8 trailer after the data words.
module test_stream_gen_mc
    import test_stream_pkg::*;
#(
    parameter int                WORD_W = 24,
    parameter int                NCHAN  = 4,
    parameter logic [WORD_W-1:0] POLY   = 24'hE10000,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        address,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  nwords,
    input  logic [WORD_W-1:0] pattern,
    output logic [NCHAN-1:0]  stream,
    output logic              busy,
    output logic              done
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] LAST_HDR = BIT_W'(7);
`ifdef TEST_STREAM_CRC_EN
    localparam state_t POST_DATA = TRLR;
`else
    localparam state_t POST_DATA = FIN;
`endif

    state_t            state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  word_cnt, nwords_q, word_cnt_inc;
    logic [1:0]        mode_q;
    logic [3:0]        address_q;
    logic [WORD_W-1:0] word, word_init, word_next;
    logic              accept, last_bit;

    assign accept       = (state == IDLE) && start && !abort;
    assign last_bit     = (state == SHFT) && (bit_cnt == LAST_BIT);
    assign word_cnt_inc = word_cnt + 1'b1;

    always_comb begin
        unique case (mode)
            MODE_FIX: word_init = pattern;
            MODE_ALT: word_init = WORD_W'({WORD_W/2{2'b10}});
            default:  word_init = '1;
        endcase
    end

    always_comb begin
        unique case (mode_q)
            MODE_DEC:  word_next = word - 1'b1;
            MODE_PRBS: word_next = {word[WORD_W-2:0], ^(word & POLY)};
            MODE_FIX:  word_next = word;
            default:   word_next = ~word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over everything, including a Start arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nxt = HEAD;
                HEAD: if (bit_cnt == LAST_HDR) state_nxt = (nwords_q == '0) ? POST_DATA : SHFT;
                SHFT: if (last_bit && (word_cnt_inc == nwords_q)) state_nxt = POST_DATA;
`ifdef TEST_STREAM_CRC_EN
                TRLR: if (bit_cnt == LAST_HDR) state_nxt = FIN;
`endif
                FIN:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            nwords_q  <= '0;
            mode_q    <= MODE_DEC;
            address_q <= 4'h0;
            word      <= '1;
        end else if (accept) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            nwords_q  <= nwords;
            mode_q    <= mode;
            address_q <= address;
            word      <= word_init;
        end else begin
            if (last_bit) begin
                word_cnt <= word_cnt_inc;
                word     <= word_next;
            end
            if ((state_nxt != state) || last_bit) begin
                bit_cnt <= '0;
            end else if (state inside {HEAD, SHFT, TRLR}) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef TEST_STREAM_CRC_EN
    logic [NCHAN-1:0][7:0] crc;

    for (genvar k = 0; k < NCHAN; k++) begin : g_crc
        test_stream_crc8 u_crc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (accept),
            .en     ((state == HEAD) || (state == SHFT)),
            .bit_in (stream[k]),
            .crc    (crc[k])
        );
    end
`endif

    // Each lane sees the word rotated left by its lane index, MSB first.
    always_comb begin
        logic [7:0]        hdr_sh;
        logic [WORD_W-1:0] lane_word;
        logic [WORD_W-1:0] lane_sh;
        stream    = '0;
        busy      = (state != IDLE);
        done      = (state == FIN);
        hdr_sh    = {HDR_MARK, address_q} << bit_cnt[2:0];
        lane_word = '0;
        lane_sh   = '0;
        unique case (state)
            HEAD: stream = {NCHAN{hdr_sh[7]}};
            SHFT: begin
                for (int k = 0; k < NCHAN; k++) begin
                    lane_word = (word << k) | (word >> (WORD_W - k));
                    lane_sh   = lane_word << bit_cnt;
                    stream[k] = lane_sh[WORD_W-1];
                end
            end
`ifdef TEST_STREAM_CRC_EN
            TRLR: begin
                for (int k = 0; k < NCHAN; k++) begin
                    hdr_sh    = crc[k] << bit_cnt[2:0];
                    stream[k] = hdr_sh[7];
                end
            end
`endif
            default: stream = '0;
        endcase
    end

endmodule
